irq_call_sequencer: RTL and testbench
=====================================

Name: irq_call_sequencer

Overview:
- Control-side sequencer directly upstream of the stack unit.
- Turns CALL and RTI instructions and external interrupt requests into single stack push/pop commands.
- Captures the return PC and flags for the push, and drives PC/flag reload into the CPU datapath once the stack unit finishes.
- Stalls the CPU from acceptance until the reload pulse.

Parameters:
- IRQ_VECTOR, 8'h01, PC loaded on interrupt entry.
- IE_BIT, 4, index of the interrupt-enable bit in flags[5:0].
- TIMEOUT, 64, maximum cycles waiting for stack completion before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- irq  in  1  external interrupt request; asynchronous, level.
- fetch_boundary  in  1  CPU is at an instruction boundary this cycle.
- call_req  in  1  CALL decoded; sampled only at fetch_boundary.
- rti_req  in  1  RTI decoded; sampled only at fetch_boundary.
- call_target  in  8  CALL destination address.
- pc_in  in  8  return address (next PC).
- flags_in  in  6  current CPU flags.
- stack_op_ongoing  out  1  start pulse to the stack unit.
- push_or_pop  out  1  0 = push, 1 = pop (PUSH/POP in control_defs.vh).
- stack_op_end  in  1  stack unit final-state indicator.
- push_pc  out  8  latched return PC, wired to stack data_in_PC.
- push_flags  out  6  latched flags, wired to stack data_in_flags.
- pop_pc  in  8  stack data_out_PC.
- pop_flags  in  6  stack data_out_flags.
- pc_load  out  1  one-cycle PC reload strobe.
- pc_load_value  out  8  new PC.
- flags_load  out  1  one-cycle flags reload strobe.
- flags_load_value  out  6  new flags.
- cpu_stall  out  1  hold CPU.
- irq_ack  out  1  one-cycle pulse on interrupt acceptance.
- seq_error  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- irq synchroniser:
  - irq passes through a 2-flop synchroniser; irq_s is the second flop.
  - Taken only when irq_s=1, flags_in[IE_BIT]=1, fetch_boundary=1 and state IDLE.
- Acceptance priority at a boundary in IDLE: rti_req > call_req > irq.
  - The loser is not queued; irq stays pending by level.
  - call_req and rti_req together: RTI wins.
- Acceptance cycle N (registered at edge N+1):
  - Latch push_pc <= pc_in and push_flags <= flags_in (push requests only).
  - Latch kind (CALL/IRQ/RTI) and call_target.
  - Clear the timeout counter.
- Cycle N+1:
  - stack_op_ongoing=1 for exactly this one cycle; never held, because the stack unit re-triggers on a level.
  - push_or_pop is valid from N+1 until return to IDLE.
  - cpu_stall=1 from N+1 through the pc_load cycle inclusive.
- States:
  - IDLE
  - START: one cycle, issues the pulse.
  - WAIT_HI: waiting for stack_op_end=1.
  - WAIT_LO: waiting for stack_op_end falling edge.
  - LOAD: one cycle; pc_load=1, plus flags_load as below.
  - Transitions: IDLE -> START -> WAIT_HI -> WAIT_LO -> LOAD -> IDLE.
- Completion is the falling edge of stack_op_end: high in the previous cycle, low now. pop_pc/pop_flags are valid only from that cycle on.
- LOAD values:
  - CALL: pc_load_value=call_target; flags_load=0.
  - IRQ: pc_load_value=IRQ_VECTOR; flags_load=1; flags_load_value=push_flags with bit IE_BIT cleared. irq_ack=1 in the START cycle.
  - RTI: pc_load_value=pop_pc; flags_load=1; flags_load_value=pop_flags.
- Timeout:
  - 7-bit counter increments each cycle in WAIT_HI/WAIT_LO.
  - On reaching TIMEOUT: set seq_error, go to IDLE, drop cpu_stall, no load.
- Requests outside IDLE are ignored. The CPU is stalled, so this occurs only via misuse.
- Reset, including mid-sequence: next cycle state IDLE; all outputs 0, counters 0, synchroniser 0, latched values 8'h00/6'h00. The stack unit is reset by the same rst.

Test Plan:
- CALL: pc_in=8'h23, flags_in=6'h10, call_target=8'h80 at boundary -> one-cycle stack_op_ongoing with push_or_pop=0; push_pc=8'h23, push_flags=6'h10; after stack_op_end fall, pc_load with 8'h80; flags_load=0; stall ends same cycle.
- IRQ entry: irq=1, flags_in=6'h10, pc_in=8'h40 -> irq_ack once; push of 8'h40/6'h10; then pc_load_value=8'h01, flags_load_value=6'h00.
- IRQ masked: irq=1, flags_in=6'h00 for 20 boundaries -> no stack_op_ongoing, no ack. Then IE set -> taken at the first boundary after 2 sync cycles.
- RTI: stack model returns pop_pc=8'h41, pop_flags=6'h15 with stack_op_end high 3 cycles (bus_grant delayed) -> push_or_pop=1; pc_load 8'h41 and flags_load 6'h15 only after the fall.
- Simultaneous call_req+rti_req+irq at one boundary -> RTI executed; irq taken at the next boundary if IE restored.
- Timeout/reset: stack_op_end stuck 0 -> seq_error after 64 cycles, IDLE, no load. Separately, rst asserted in WAIT_LO -> all outputs 0 next cycle.

Source files
------------

// File: rtl/irq_call_sequencer.sv
// Turns CALL, RTI and external interrupts into single stack push/pop commands,
// stalls the CPU meanwhile and reloads PC/flags once the stack unit finishes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an accepted request at an instruction boundary
// START   | one-cycle start pulse to the stack unit
// WAIT_HI | waiting for stack_op_end to rise
// WAIT_LO | waiting for stack_op_end to fall (completion)
// LOAD    | one-cycle PC/flags reload strobe
module irq_call_sequencer #(
  parameter logic [7:0] IRQ_VECTOR = 8'h01,
  parameter int         IE_BIT     = 4,
  parameter int         TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq,
  input  logic       fetch_boundary,
  input  logic       call_req,
  input  logic       rti_req,
  input  logic [7:0] call_target,
  input  logic [7:0] pc_in,
  input  logic [5:0] flags_in,
  output logic       stack_op_ongoing,
  output logic       push_or_pop,
  input  logic       stack_op_end,
  output logic [7:0] push_pc,
  output logic [5:0] push_flags,
  input  logic [7:0] pop_pc,
  input  logic [5:0] pop_flags,
  output logic       pc_load,
  output logic [7:0] pc_load_value,
  output logic       flags_load,
  output logic [5:0] flags_load_value,
  output logic       cpu_stall,
  output logic       irq_ack,
  output logic       seq_error
);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, LOAD} state_t;
  typedef enum logic [1:0] {K_CALL, K_IRQ, K_RTI} kind_t;

  localparam logic       PUSH    = 1'b0;
  localparam logic       POP     = 1'b1;
  localparam logic [6:0] TC      = 7'(TIMEOUT - 1);
  localparam logic [5:0] IE_MASK = 6'b1 << IE_BIT;

  state_t     state;
  kind_t      kind;
  logic [7:0] target;
  logic [6:0] wait_cnt;
  logic       irq_m;
  logic       irq_s;
  logic       irq_ok;
  logic       op_done;

  assign irq_ok = irq_s & flags_in[IE_BIT];
  // WAIT_LO is only held while stack_op_end stays high, so a low here is the falling edge.
  assign op_done = (state == WAIT_LO) & ~stack_op_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      kind             <= K_CALL;
      target           <= 8'h00;
      wait_cnt         <= 7'd0;
      irq_m            <= 1'b0;
      irq_s            <= 1'b0;
      stack_op_ongoing <= 1'b0;
      push_or_pop      <= 1'b0;
      push_pc          <= 8'h00;
      push_flags       <= 6'h00;
      pc_load          <= 1'b0;
      pc_load_value    <= 8'h00;
      flags_load       <= 1'b0;
      flags_load_value <= 6'h00;
      cpu_stall        <= 1'b0;
      irq_ack          <= 1'b0;
      seq_error        <= 1'b0;
    end else begin
      irq_m            <= irq;
      irq_s            <= irq_m;
      stack_op_ongoing <= 1'b0;
      irq_ack          <= 1'b0;
      pc_load          <= 1'b0;
      flags_load       <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_boundary && (rti_req || call_req || irq_ok)) begin
            state            <= START;
            stack_op_ongoing <= 1'b1;
            cpu_stall        <= 1'b1;
            target           <= call_target;
            wait_cnt         <= 7'd0;
            if (rti_req) begin
              kind        <= K_RTI;
              push_or_pop <= POP;
            end else begin
              kind        <= call_req ? K_CALL : K_IRQ;
              irq_ack     <= ~call_req;
              push_or_pop <= PUSH;
              push_pc     <= pc_in;
              push_flags  <= flags_in;
            end
          end
        end
        START: state <= WAIT_HI;
        WAIT_HI, WAIT_LO: begin
          if (op_done) begin
            state   <= LOAD;
            pc_load <= 1'b1;
            case (kind)
              K_CALL: pc_load_value <= target;
              K_IRQ: begin
                pc_load_value    <= IRQ_VECTOR;
                flags_load       <= 1'b1;
                flags_load_value <= push_flags & ~IE_MASK;
              end
              default: begin
                pc_load_value    <= pop_pc;
                flags_load       <= 1'b1;
                flags_load_value <= pop_flags;
              end
            endcase
          end else if (wait_cnt == TC) begin
            seq_error   <= 1'b1;
            state       <= IDLE;
            cpu_stall   <= 1'b0;
            push_or_pop <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 7'd1;
            if (state == WAIT_HI && stack_op_end) state <= WAIT_LO;
          end
        end
        LOAD: begin
          state            <= IDLE;
          cpu_stall        <= 1'b0;
          push_or_pop      <= 1'b0;
          pc_load_value    <= 8'h00;
          flags_load_value <= 6'h00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_call_sequencer.sv
// Bench for irq_call_sequencer: fixed vector table, hand-built corner sequences
// and random transactions against a request/stack-level reference model.
module tb_irq_call_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic       fetch_boundary;
  logic       call_req;
  logic       rti_req;
  logic [7:0] call_target;
  logic [7:0] pc_in;
  logic [5:0] flags_in;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic       stack_op_end;
  logic [7:0] push_pc;
  logic [5:0] push_flags;
  logic [7:0] pop_pc;
  logic [5:0] pop_flags;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       flags_load;
  logic [5:0] flags_load_value;
  logic       cpu_stall;
  logic       irq_ack;
  logic       seq_error;

  irq_call_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .fetch_boundary(fetch_boundary),
    .call_req(call_req), .rti_req(rti_req), .call_target(call_target),
    .pc_in(pc_in), .flags_in(flags_in), .stack_op_ongoing(stack_op_ongoing),
    .push_or_pop(push_or_pop), .stack_op_end(stack_op_end), .push_pc(push_pc),
    .push_flags(push_flags), .pop_pc(pop_pc), .pop_flags(pop_flags),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .flags_load(flags_load),
    .flags_load_value(flags_load_value), .cpu_stall(cpu_stall),
    .irq_ack(irq_ack), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rti, call, irq;
    logic [5:0] flags;
    logic [7:0] pc, tgt;
    int         d1, h;
    logic       taken, exp_pop, exp_ack;
    logic [7:0] exp_pc;
    logic       exp_fl;
    logic [5:0] exp_flv;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [5:0] fl;
  } ent_t;

  int   n_pass = 0;
  int   n_total = 0;
  ent_t stk[$];
  vec_t tbl[11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic rti, input logic call, input logic irq_v,
                              input logic [5:0] fl, input logic [7:0] pc, input logic [7:0] tgt,
                              input int d1, input int h, input logic tk, input logic pop,
                              input logic ack, input logic [7:0] epc, input logic efl,
                              input logic [5:0] eflv);
    vec_t v;
    v.rti = rti; v.call = call; v.irq = irq_v; v.flags = fl; v.pc = pc; v.tgt = tgt;
    v.d1 = d1; v.h = h; v.taken = tk; v.exp_pop = pop; v.exp_ack = ack;
    v.exp_pc = epc; v.exp_fl = efl; v.exp_flv = eflv;
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ongoing"}, stack_op_ongoing, 0);
    check({tag, "_dir"}, push_or_pop, 0);
    check({tag, "_push_pc"}, push_pc, 0);
    check({tag, "_push_flags"}, push_flags, 0);
    check({tag, "_pc_load"}, {pc_load, pc_load_value}, 0);
    check({tag, "_flags_load"}, {flags_load, flags_load_value}, 0);
    check({tag, "_stall"}, cpu_stall, 0);
    check({tag, "_ack"}, irq_ack, 0);
    check({tag, "_err"}, seq_error, 0);
  endtask

  task automatic do_reset;
    irq = 0; fetch_boundary = 0; call_req = 0; rti_req = 0; stack_op_end = 0;
    rst = 1;
    tick;
    tick;
    rst = 0;
    stk.delete();
  endtask

  // Present the request at one boundary; returns in the cycle after it.
  task automatic issue(input vec_t v);
    irq = v.irq; fetch_boundary = 0; stack_op_end = 0;
    repeat (3) tick;
    pc_in = v.pc; flags_in = v.flags; call_target = v.tgt;
    call_req = v.call; rti_req = v.rti; fetch_boundary = 1;
    tick;
    fetch_boundary = 0; call_req = 0; rti_req = 0;
    pc_in = ~v.pc; flags_in = ~v.flags; call_target = ~v.tgt;
  endtask

  // Starting in the pulse cycle: checks the command, plays the stack unit, checks the reload.
  task automatic run_accepted(input vec_t v);
    ent_t e;
    check("pulse", stack_op_ongoing, 1);
    check("dir", push_or_pop, v.exp_pop);
    check("ack", irq_ack, v.exp_ack);
    check("stall_start", cpu_stall, 1);
    e.pc = 8'h00; e.fl = 6'h00;
    if (!v.exp_pop) begin
      check("push_pc", push_pc, v.pc);
      check("push_flags", push_flags, v.flags);
      e.pc = v.pc; e.fl = v.flags;
      stk.push_back(e);
    end else if (stk.size() > 0) begin
      e = stk.pop_back();
    end
    if (v.exp_ack) irq = 0;
    pop_pc = ~e.pc; pop_flags = ~e.fl;
    tick;
    check("pulse_once", stack_op_ongoing, 0);
    check("ack_once", irq_ack, 0);
    for (int i = 0; i < v.d1; i++) begin
      stack_op_end = 0;
      tick;
      check("early_load", pc_load, 0);
    end
    for (int i = 0; i < v.h; i++) begin
      stack_op_end = 1;
      tick;
      check("early_load", pc_load, 0);
      check("stall_wait", cpu_stall, 1);
    end
    stack_op_end = 0; pop_pc = e.pc; pop_flags = e.fl;
    tick;
    pop_pc = ~e.pc; pop_flags = ~e.fl;
    check("pc_load", pc_load, 1);
    check("pc_load_value", pc_load_value, v.exp_pc);
    check("flags_load", flags_load, v.exp_fl);
    if (v.exp_fl) check("flags_load_value", flags_load_value, v.exp_flv);
    check("stall_in_load", cpu_stall, 1);
    check("dir_in_load", push_or_pop, v.exp_pop);
    tick;
    check("load_once", {pc_load, flags_load}, 0);
    check("stall_end", cpu_stall, 0);
    check("dir_idle", push_or_pop, 0);
    check("no_err", seq_error, 0);
  endtask

  task automatic do_txn(input vec_t v);
    issue(v);
    if (v.taken) run_accepted(v);
    else begin
      check("not_taken_pulse", stack_op_ongoing, 0);
      check("not_taken_ack", irq_ack, 0);
      check("not_taken_stall", cpu_stall, 0);
    end
  endtask

  // Reference model: priority RTI > CALL > enabled IRQ, LIFO stack contents.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    r.taken = 1; r.exp_ack = 0; r.exp_fl = 0; r.exp_flv = 6'h00; r.exp_pop = 0;
    if (v.rti) begin
      r.exp_pop = 1; r.exp_pc = stk[$].pc; r.exp_fl = 1; r.exp_flv = stk[$].fl;
    end else if (v.call) begin
      r.exp_pc = v.tgt;
    end else if (v.irq && v.flags[4]) begin
      r.exp_ack = 1; r.exp_pc = 8'h01; r.exp_fl = 1; r.exp_flv = v.flags & 6'h2F;
    end else begin
      r.taken = 0;
    end
    return r;
  endfunction

  initial begin
    vec_t v;
    tbl[0]  = mk(0, 1, 0, 6'h10, 8'h23, 8'h80, 1, 2, 1, 0, 0, 8'h80, 0, 6'h00);
    tbl[1]  = mk(0, 0, 1, 6'h10, 8'h40, 8'h00, 0, 1, 1, 0, 1, 8'h01, 1, 6'h00);
    tbl[2]  = mk(1, 0, 0, 6'h00, 8'h00, 8'h00, 2, 1, 1, 1, 0, 8'h40, 1, 6'h10);
    tbl[3]  = mk(0, 1, 0, 6'h15, 8'h41, 8'h9C, 0, 2, 1, 0, 0, 8'h9C, 0, 6'h00);
    tbl[4]  = mk(1, 0, 0, 6'h00, 8'h00, 8'h00, 1, 3, 1, 1, 0, 8'h41, 1, 6'h15);
    tbl[5]  = mk(1, 1, 1, 6'h10, 8'h60, 8'h70, 0, 1, 1, 1, 0, 8'h23, 1, 6'h10);
    tbl[6]  = mk(0, 0, 1, 6'h13, 8'h55, 8'h00, 1, 1, 1, 0, 1, 8'h01, 1, 6'h03);
    tbl[7]  = mk(0, 0, 1, 6'h2F, 8'h66, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 6'h00);
    tbl[8]  = mk(0, 1, 1, 6'h10, 8'h77, 8'hA5, 0, 1, 1, 0, 0, 8'hA5, 0, 6'h00);
    tbl[9]  = mk(1, 0, 0, 6'h00, 8'h00, 8'h00, 0, 1, 1, 1, 0, 8'h77, 1, 6'h10);
    tbl[10] = mk(1, 0, 0, 6'h00, 8'h00, 8'h00, 3, 4, 1, 1, 0, 8'h55, 1, 6'h13);

    pc_in = 0; flags_in = 0; call_target = 0; pop_pc = 0; pop_flags = 0;
    do_reset;
    check_zero("reset");

    for (int i = 0; i < 11; i++) do_txn(tbl[i]);

    // Masked interrupt held for 20 boundaries, then IE set.
    irq = 1; flags_in = 6'h00; pc_in = 8'h40;
    repeat (3) tick;
    fetch_boundary = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      check("masked_pulse", {stack_op_ongoing, irq_ack}, 0);
    end
    flags_in = 6'h10;
    tick;
    fetch_boundary = 0;
    run_accepted(mk(0, 0, 1, 6'h10, 8'h40, 8'h00, 0, 2, 1, 0, 1, 8'h01, 1, 6'h00));
    do_txn(mk(1, 0, 0, 6'h00, 8'h00, 8'h00, 0, 1, 1, 1, 0, 8'h40, 1, 6'h10));

    // Stack unit never answers.
    v = mk(0, 1, 0, 6'h10, 8'h31, 8'hC0, 0, 1, 1, 0, 0, 8'hC0, 0, 6'h00);
    issue(v);
    check("to_pulse", stack_op_ongoing, 1);
    repeat (64) tick;
    check("to_early_err", seq_error, 0);
    check("to_stall_held", cpu_stall, 1);
    tick;
    check("to_err", seq_error, 1);
    check("to_stall_drop", cpu_stall, 0);
    check("to_no_load", {pc_load, flags_load}, 0);
    repeat (3) tick;
    check("to_sticky", seq_error, 1);
    check("to_no_load_late", pc_load, 0);
    do_reset;
    check("to_err_clr", seq_error, 0);

    // Reset while waiting for the falling edge.
    v = mk(0, 1, 0, 6'h3F, 8'h77, 8'h12, 0, 1, 1, 0, 0, 8'h12, 0, 6'h00);
    issue(v);
    tick;
    stack_op_end = 1;
    tick;
    check("wlo_stall", cpu_stall, 1);
    check("wlo_push_pc", push_pc, 8'h77);
    rst = 1;
    tick;
    rst = 0; stack_op_end = 0;
    stk.delete();
    check_zero("wlo_rst");

    for (int n = 0; n < 40; n++) begin
      v.rti   = (stk.size() > 0) ? ($urandom_range(2) == 0) : 1'b0;
      v.call  = 1'($urandom_range(1));
      v.irq   = 1'($urandom_range(1));
      v.flags = 6'($urandom);
      v.pc    = 8'($urandom);
      v.tgt   = 8'($urandom);
      v.d1    = int'($urandom_range(3));
      v.h     = int'($urandom_range(4, 1));
      do_txn(predict(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
